apb_slave: RTL and testbench
============================

// Module: apb_slave
// PURPOSE
//  APB (AMBA3-style) completer exposing a bank of 32-bit read/write registers.
//  - Sits behind an APB bridge or interconnect as a simple memory-mapped register file.
//  - Supports programmable wait states and word-aligned addressing.
//  - Accepts transfers whose setup and access phases collapse into one cycle (PSEL and PENABLE asserted together).
// PARAMETERS
//  ADDR_WIDTH   32  PADDR width
//  DATA_WIDTH   32  PWDATA/PRDATA width and register width
//  NUM_REGS     16  number of registers; power of 2, >=2
//  WAIT_STATES  0   cycles PREADY is held low before each transfer completes
// PORTS
//  PCLK     in   1           clock; all state updates on the rising edge
//  PRESETn  in   1           reset; synchronous, active-high (legacy name keeps the 'n')
//  PSEL     in   1           slave select
//  PENABLE  in   1           access phase
//  PWRITE   in   1           1=write, 0=read
//  PADDR    in   ADDR_WIDTH  byte address
//  PWDATA   in   DATA_WIDTH  write data
//  PRDATA   out  DATA_WIDTH  read data
//  PREADY   out  1           transfer completes on the edge where PSEL&PENABLE&PREADY
//  PSLVERR  out  1           error response; present only with APB_SLAVE_PSLVERR_EN
// BEHAVIOUR
//  - Interface: one clock; reset is synchronous and active-high.
//  - Reset: all registers and the wait counter clear to 0 on the rising edge with PRESETn=1.
//  - During reset, PRDATA=0 and PREADY=0; any transfer in progress is aborted with no write.
//  - Decode: idx = PADDR[2 +: log2(NUM_REGS)]; PADDR[1:0] ignored.
//  - Decode range: in range iff PADDR < NUM_REGS*4.
//  - Access: active = PSEL & PENABLE; no separate setup cycle is required.
//  - Wait counter: increments each active cycle while < WAIT_STATES.
//  - Wait counter clears when PSEL drops or a transfer completes.
//  - PREADY: combinational; PREADY = active & (wait_cnt == WAIT_STATES).
//  - PREADY is 0 whenever not active; with WAIT_STATES=0, PREADY=1 in the first active cycle.
//  - Write: on the completing edge with PWRITE=1 and in-range address, reg[idx] <= PWDATA.
//  - Write: out-of-range writes are ignored.
//  - Read: PRDATA combinational; PRDATA = reg[idx] when PSEL & ~PWRITE & in-range, else 0.
//  - Read has no side effects.
//  - A write completing on an edge is visible to a read of the same register in the next cycle.
//  - Back-to-back transfers are allowed: PSEL/PENABLE may stay high across consecutive completions.
//  - Each completion starts a fresh wait count.
//  - PADDR/PWRITE/PWDATA must be stable while active and PREADY=0.
//  - PADDR/PWRITE/PWDATA are sampled only at the completing edge.
//  - PENABLE without PSEL is ignored.
// CONFIGURATION
//  APB_SLAVE_PSLVERR_EN defined:
//  - PSLVERR port exists.
//  - PSLVERR = PREADY & out-of-range address; it is 0 at all other times.
//  - Out-of-range writes are still discarded and out-of-range reads return 0.
//  APB_SLAVE_PSLVERR_EN undefined:
//  - No PSLVERR port.
//  - Out-of-range accesses complete silently.
// TESTING
//  1. Hold PRESETn=1 for 2 clks, then read idx 0..15 -> PRDATA=0 and no writes occur.
//  2. WAIT_STATES=0: PSEL=PENABLE=PWRITE=1, PADDR=0x00, PWDATA=0xDEADBEFF for 1 clk.
//     Drop PSEL, then read 0x00 -> PRDATA=0xDEADBEFF; PREADY=1 in each access cycle.
//  3. Write 0x11111111 to 0x04 and 0x22222222 to 0x3C back-to-back.
//     Read both -> values match; 0x00 is unchanged.
//  4. WAIT_STATES=2: write 0xA5A5A5A5 to 0x08.
//     PREADY is low for 2 active cycles, high in the 3rd; the register updates only on the 3rd edge.
//  5. PRESETn=1 during a wait-stated write -> no update; the following read returns 0.
//  6. Write/read 0x40 (out of range) -> write dropped and PRDATA=0.
//     With APB_SLAVE_PSLVERR_EN, PSLVERR=1 coincident with PREADY.

Source files
------------

// File: rtl/apb_slave.sv
// apb_slave: APB completer with NUM_REGS x DATA_WIDTH registers, WAIT_STATES wait cycles per transfer.
// Define APB_SLAVE_PSLVERR_EN to add a PSLVERR port flagging out-of-range accesses.
module apb_slave #(
  parameter int ADDR_WIDTH  = 32,
  parameter int DATA_WIDTH  = 32,
  parameter int NUM_REGS    = 16,
  parameter int WAIT_STATES = 0
) (
  input  logic                  PCLK,
  input  logic                  PRESETn,
  input  logic                  PSEL,
  input  logic                  PENABLE,
  input  logic                  PWRITE,
  input  logic [ADDR_WIDTH-1:0] PADDR,
  input  logic [DATA_WIDTH-1:0] PWDATA,
  output logic [DATA_WIDTH-1:0] PRDATA,
  output logic                  PREADY
`ifdef APB_SLAVE_PSLVERR_EN
  ,
  output logic                  PSLVERR
`endif
);
  localparam int IDX_W = $clog2(NUM_REGS);
  localparam int CNT_W = (WAIT_STATES > 0) ? $clog2(WAIT_STATES + 1) : 1;
  localparam logic [CNT_W-1:0]      CNT_MAX  = CNT_W'(WAIT_STATES);
  localparam logic [ADDR_WIDTH-1:0] ADDR_END = ADDR_WIDTH'(NUM_REGS * 4);

  logic [DATA_WIDTH-1:0] regs_q [NUM_REGS];
  logic [DATA_WIDTH-1:0] regs_d [NUM_REGS];
  logic [CNT_W-1:0]      wait_cnt_q;
  logic [CNT_W-1:0]      wait_cnt_d;
  logic                  active;
  logic                  in_range;
  logic                  ready;
  logic [IDX_W-1:0]      idx;

  assign active   = PSEL & PENABLE;
  assign in_range = (PADDR < ADDR_END);
  assign idx      = PADDR[2 +: IDX_W];
  // PRESETn is active-high here; it masks completion so an in-flight write is dropped.
  assign ready    = ~PRESETn & active & (wait_cnt_q == CNT_MAX);

  always_comb begin
    wait_cnt_d = wait_cnt_q;
    regs_d     = regs_q;
    if (!PSEL || ready) begin
      wait_cnt_d = '0;
    end else if (active && (wait_cnt_q != CNT_MAX)) begin
      wait_cnt_d = wait_cnt_q + 1'b1;
    end
    if (ready && PWRITE && in_range) begin
      regs_d[idx] = PWDATA;
    end
  end

  always_ff @(posedge PCLK) begin
    if (PRESETn) begin
      wait_cnt_q <= '0;
      for (int i = 0; i < NUM_REGS; i++) begin
        regs_q[i] <= '0;
      end
    end else begin
      wait_cnt_q <= wait_cnt_d;
      regs_q     <= regs_d;
    end
  end

  assign PREADY = ready;
  assign PRDATA = (~PRESETn & PSEL & ~PWRITE & in_range) ? regs_q[idx] : '0;

`ifdef APB_SLAVE_PSLVERR_EN
  assign PSLVERR = ready & ~in_range;
`endif

endmodule

// File: tb/tb_apb_slave.sv
// Directed bench for apb_slave: one instance with no wait states, one with two.
module tb_apb_slave;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        psel0 = 1'b0, psel2 = 1'b0;
  logic        penable = 1'b0, pwrite = 1'b0;
  logic [31:0] paddr = '0, pwdata = '0;
  logic [31:0] prdata0, prdata2;
  logic        pready0, pready2;
`ifdef APB_SLAVE_PSLVERR_EN
  logic        pslverr0, pslverr2;
`endif
  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  apb_slave #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .NUM_REGS(16), .WAIT_STATES(0)) dut0 (
    .PCLK(clk), .PRESETn(rst), .PSEL(psel0), .PENABLE(penable), .PWRITE(pwrite),
    .PADDR(paddr), .PWDATA(pwdata), .PRDATA(prdata0), .PREADY(pready0)
`ifdef APB_SLAVE_PSLVERR_EN
    , .PSLVERR(pslverr0)
`endif
  );

  apb_slave #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .NUM_REGS(16), .WAIT_STATES(2)) dut2 (
    .PCLK(clk), .PRESETn(rst), .PSEL(psel2), .PENABLE(penable), .PWRITE(pwrite),
    .PADDR(paddr), .PWDATA(pwdata), .PRDATA(prdata2), .PREADY(pready2)
`ifdef APB_SLAVE_PSLVERR_EN
    , .PSLVERR(pslverr2)
`endif
  );

  function automatic logic get_ready(input bit w);
    return w ? pready2 : pready0;
  endfunction

  function automatic logic [31:0] get_rdata(input bit w);
    return w ? prdata2 : prdata0;
  endfunction

  // One bus cycle: inputs change after the falling edge, outputs are looked at 1ns later.
  task automatic drive(input bit w, input logic sel, input logic en, input logic wr,
                       input logic [31:0] a, input logic [31:0] d);
    @(negedge clk);
    psel0   = w ? 1'b0 : sel;
    psel2   = w ? sel : 1'b0;
    penable = en;
    pwrite  = wr;
    paddr   = a;
    pwdata  = d;
    #1;
  endtask

  task automatic idle();
    drive(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
  endtask

  task automatic do_read(input bit w, input logic [31:0] a, output logic [31:0] d);
    int n;
    n = 0;
    drive(w, 1'b1, 1'b1, 1'b0, a, 32'h0);
    while (!get_ready(w) && n < 20) begin
      n++;
      drive(w, 1'b1, 1'b1, 1'b0, a, 32'h0);
    end
    checks++;
    if (get_ready(w) !== 1'b1) begin
      errors++;
      $display("FAIL read_timeout addr=%h: pready=%b required 1", a, get_ready(w));
    end
    d = get_rdata(w);
    idle();
  endtask

  task automatic test_reset();
    logic [31:0] d;
    drive(1'b0, 1'b1, 1'b1, 1'b1, 32'h0, 32'hFFFF_FFFF);
    checks++;
    if (pready0 !== 1'b0) begin
      errors++; $display("FAIL reset_pready: got %b required 0", pready0);
    end
    drive(1'b0, 1'b1, 1'b1, 1'b0, 32'h0, 32'h0);
    checks++;
    if (prdata0 !== 32'h0 || pready0 !== 1'b0) begin
      errors++; $display("FAIL reset_read: prdata=%h pready=%b required 0/0", prdata0, pready0);
    end
    idle();
    rst = 1'b0;
    for (int i = 0; i < 16; i++) begin
      do_read(1'b0, 32'(i * 4), d);
      checks++;
      if (d !== 32'h0) begin
        errors++; $display("FAIL reset_reg%0d: got %h required 0", i, d);
      end
    end
  endtask

  task automatic test_write_basic();
    drive(1'b0, 1'b1, 1'b1, 1'b1, 32'h0, 32'hDEAD_BEFF);
    checks++;
    if (pready0 !== 1'b1) begin
      errors++; $display("FAIL ws0_write_pready: got %b required 1", pready0);
    end
    idle();
    drive(1'b0, 1'b1, 1'b1, 1'b0, 32'h0, 32'h0);
    checks++;
    if (pready0 !== 1'b1 || prdata0 !== 32'hDEAD_BEFF) begin
      errors++; $display("FAIL ws0_read: pready=%b prdata=%h required 1/deadbeff", pready0, prdata0);
    end
    idle();
  endtask

  task automatic test_back_to_back();
    logic [31:0] d;
    drive(1'b0, 1'b1, 1'b1, 1'b1, 32'h04, 32'h1111_1111);
    checks++;
    if (pready0 !== 1'b1) begin
      errors++; $display("FAIL b2b_first_pready: got %b required 1", pready0);
    end
    drive(1'b0, 1'b1, 1'b1, 1'b1, 32'h3C, 32'h2222_2222);
    checks++;
    if (pready0 !== 1'b1) begin
      errors++; $display("FAIL b2b_second_pready: got %b required 1", pready0);
    end
    idle();
    do_read(1'b0, 32'h04, d);
    checks++;
    if (d !== 32'h1111_1111) begin errors++; $display("FAIL b2b_read04: got %h required 11111111", d); end
    do_read(1'b0, 32'h3C, d);
    checks++;
    if (d !== 32'h2222_2222) begin errors++; $display("FAIL b2b_read3c: got %h required 22222222", d); end
    do_read(1'b0, 32'h00, d);
    checks++;
    if (d !== 32'hDEAD_BEFF) begin errors++; $display("FAIL b2b_read00: got %h required deadbeff", d); end
  endtask

  task automatic test_wait_states();
    logic [31:0] d;
    logic [2:0]  exp_rdy;
    exp_rdy = 3'b100;
    // Abandon after two wait cycles: nothing may have been written yet.
    for (int c = 0; c < 2; c++) begin
      drive(1'b1, 1'b1, 1'b1, 1'b1, 32'h08, 32'hA5A5_A5A5);
      checks++;
      if (pready2 !== 1'b0) begin errors++; $display("FAIL ws2_abort_pready c%0d: got %b required 0", c, pready2); end
    end
    idle();
    do_read(1'b1, 32'h08, d);
    checks++;
    if (d !== 32'h0) begin errors++; $display("FAIL ws2_abort_read: got %h required 0", d); end
    for (int c = 0; c < 3; c++) begin
      drive(1'b1, 1'b1, 1'b1, 1'b1, 32'h08, 32'hA5A5_A5A5);
      checks++;
      if (pready2 !== exp_rdy[c]) begin
        errors++; $display("FAIL ws2_write_pready c%0d: got %b required %b", c, pready2, exp_rdy[c]);
      end
    end
    for (int c = 0; c < 3; c++) begin
      drive(1'b1, 1'b1, 1'b1, 1'b1, 32'h10, 32'h0F0F_0F0F);
      checks++;
      if (pready2 !== exp_rdy[c]) begin
        errors++; $display("FAIL ws2_b2b_pready c%0d: got %b required %b", c, pready2, exp_rdy[c]);
      end
    end
    idle();
    do_read(1'b1, 32'h08, d);
    checks++;
    if (d !== 32'hA5A5_A5A5) begin errors++; $display("FAIL ws2_read08: got %h required a5a5a5a5", d); end
    do_read(1'b1, 32'h10, d);
    checks++;
    if (d !== 32'h0F0F_0F0F) begin errors++; $display("FAIL ws2_read10: got %h required 0f0f0f0f", d); end
  endtask

  task automatic test_reset_during_wait();
    logic [31:0] d;
    drive(1'b1, 1'b1, 1'b1, 1'b1, 32'h0C, 32'h1234_5678);
    drive(1'b1, 1'b1, 1'b1, 1'b1, 32'h0C, 32'h1234_5678);
    drive(1'b1, 1'b1, 1'b1, 1'b1, 32'h0C, 32'h1234_5678);
    rst = 1'b1;
    #1;
    checks++;
    if (pready2 !== 1'b0) begin errors++; $display("FAIL rst_wait_pready: got %b required 0", pready2); end
    idle();
    rst = 1'b0;
    do_read(1'b1, 32'h0C, d);
    checks++;
    if (d !== 32'h0) begin errors++; $display("FAIL rst_wait_read0c: got %h required 0", d); end
    do_read(1'b1, 32'h08, d);
    checks++;
    if (d !== 32'h0) begin errors++; $display("FAIL rst_wait_read08: got %h required 0", d); end
  endtask

  task automatic test_out_of_range();
    logic [31:0] d;
    drive(1'b0, 1'b1, 1'b1, 1'b1, 32'h00, 32'h5A5A_5A5A);
`ifdef APB_SLAVE_PSLVERR_EN
    checks++;
    if (pslverr0 !== 1'b0) begin errors++; $display("FAIL oor_inrange_slverr: got %b required 0", pslverr0); end
`endif
    drive(1'b0, 1'b1, 1'b1, 1'b1, 32'h40, 32'hFFFF_FFFF);
    checks++;
    if (pready0 !== 1'b1) begin errors++; $display("FAIL oor_write_pready: got %b required 1", pready0); end
`ifdef APB_SLAVE_PSLVERR_EN
    checks++;
    if (pslverr0 !== 1'b1) begin errors++; $display("FAIL oor_write_slverr: got %b required 1", pslverr0); end
`endif
    idle();
    drive(1'b0, 1'b1, 1'b1, 1'b0, 32'h40, 32'h0);
    checks++;
    if (prdata0 !== 32'h0 || pready0 !== 1'b1) begin
      errors++; $display("FAIL oor_read: prdata=%h pready=%b required 0/1", prdata0, pready0);
    end
`ifdef APB_SLAVE_PSLVERR_EN
    checks++;
    if (pslverr0 !== 1'b1) begin errors++; $display("FAIL oor_read_slverr: got %b required 1", pslverr0); end
`endif
    idle();
    do_read(1'b0, 32'h00, d);
    checks++;
    if (d !== 32'h5A5A_5A5A) begin errors++; $display("FAIL oor_alias00: got %h required 5a5a5a5a", d); end
    drive(1'b0, 1'b0, 1'b1, 1'b1, 32'h00, 32'h0);
    checks++;
    if (pready0 !== 1'b0) begin errors++; $display("FAIL penable_only_pready: got %b required 0", pready0); end
    idle();
    do_read(1'b0, 32'h03, d);
    checks++;
    if (d !== 32'h5A5A_5A5A) begin errors++; $display("FAIL byte_offset_read: got %h required 5a5a5a5a", d); end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_write_basic();
    test_back_to_back();
    test_wait_states();
    test_reset_during_wait();
    test_out_of_range();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
